// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
//   Shares the read port of one asynchronous FIFO among NREQ consumers that
//   live in the FIFO's read clock domain. Round-robin grant, up to BURST pops
//   per grant, every popped word returned tagged with its owner's index.
//
// Ports
//   clk         read-domain clock, rising edge
//   rst         synchronous active-high reset
//   req         per-requester read request (level)
//   gnt         one-hot grant (registered)
//   fifo_empty  FIFO empty flag, already synchronised to clk
//   fifo_rd_en  FIFO pop strobe (combinational from state and inputs)
//   fifo_rdata  FIFO read data, valid the cycle after fifo_rd_en
//   dout        returned word (registered, held while dout_valid is low)
//   dout_valid  one-cycle strobe per returned word
//   dout_id     index of the requester that owns dout
module fifo_read_arbiter #(
  parameter int NREQ   = 4,
  parameter int BURST  = 4,
  parameter int DWIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DWIDTH-1:0]       fifo_rdata,
  output logic [DWIDTH-1:0]       dout,
  output logic                    dout_valid,
  output logic [$clog2(NREQ)-1:0] dout_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    last_q,  last_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [NREQ-1:0]   gnt_q,   gnt_d;

  logic              tag_valid_q;
  logic [IDW-1:0]    tag_q;
  logic [DWIDTH-1:0] dout_q;
  logic              dout_valid_q;
  logic [IDW-1:0]    dout_id_q;

  logic              pop;
  logic [CW-1:0]     cnt_inc;
  logic [IDW-1:0]    winner;

  // Candidate table: slot gi holds the requester index at distance gi+1
  // from the previous winner, so slot 0 has the highest priority.
  logic [IDW-1:0]    cand_idx [NREQ];
  logic [NREQ-1:0]   cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDW'((int'(last_q) + gi + 1) % NREQ);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Walk from lowest priority to highest so the nearest set request wins.
  always_comb begin
    winner = last_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        winner = cand_idx[i];
      end
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req && !fifo_empty) begin
          state_d = GRANT;
          owner_d = winner;
          last_d  = winner;
          cnt_d   = '0;
          gnt_d   = NREQ'(1) << winner;
        end
      end
      GRANT: begin
        // An empty FIFO just stalls the grant: nobody else could read anyway.
        pop = req[owner_q] && !fifo_empty && (cnt_q < CW'(BURST));
        if (pop) begin
          cnt_d = cnt_inc;
        end
        if (!req[owner_q] || (pop && (cnt_inc == CW'(BURST)))) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  // Return path: the owner is tagged at pop time and paired with the FIFO
  // data one cycle later. Reset empties the tag pipe, so a pop issued in the
  // reset cycle, and any word still in flight, is never presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_q  <= 1'b0;
      tag_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_id_q    <= '0;
    end else begin
      tag_valid_q  <= pop;
      if (pop) begin
        tag_q <= owner_q;
      end
      dout_valid_q <= tag_valid_q;
      if (tag_valid_q) begin
        dout_q    <= fifo_rdata;
        dout_id_q <= tag_q;
      end
    end
  end

  assign gnt        = gnt_q;
  assign fifo_rd_en = pop;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_id    = dout_id_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: a queue-based FIFO, a grant-level round-robin
// reference and a scoreboard of expected returned words (data, owner, due
// cycle). Directed scenarios followed by randomized traffic.
module tb_fifo_read_arbiter;

  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int DW    = 8;
  localparam int IDW   = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic            fifo_empty = 1'b1;
  logic            fifo_rd_en;
  logic [DW-1:0]   fifo_rdata = '0;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic [IDW-1:0]  dout_id;

  always #5 clk = ~clk;

  fifo_read_arbiter #(.NREQ(NREQ), .BURST(BURST), .DWIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_id    (dout_id)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            id;
    int            due;
  } ret_t;

  ret_t            exp_q[$];
  logic [DW-1:0]   fifo_q[$];
  logic [NREQ-1:0] gnt_log[$];
  logic [NREQ-1:0] prev_gnt = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pops_total = 0;

  // Grant-level reference state.
  bit            m_busy  = 1'b0;
  int            m_owner = 0;
  int            m_last  = NREQ - 1;
  int            m_cnt   = 0;
  logic [DW-1:0] m_dout  = '0;
  int            m_id    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs, compare outputs against the reference,
  // then advance the FIFO and the reference across the rising edge.
  task automatic cycle(input logic [NREQ-1:0] r, input bit st, input bit rs);
    bit              exp_rd;
    bit              act_rd;
    bit              empty_now;
    logic [NREQ-1:0] exp_gnt;
    logic [DW-1:0]   w;
    ret_t            e;
    @(negedge clk);
    rst        = rs;
    req        = r;
    empty_now  = st || (fifo_q.size() == 0);
    fifo_empty = empty_now;
    #1;
    exp_gnt = m_busy ? (NREQ'(1) << m_owner) : '0;
    exp_rd  = m_busy && r[m_owner] && !empty_now && (m_cnt < BURST);
    check_val("gnt", 32'(gnt), 32'(exp_gnt));
    check_val("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check_val("dout_valid", 32'(dout_valid), 32'd1);
      check_val("dout", 32'(dout), 32'(e.data));
      check_val("dout_id", 32'(dout_id), 32'(e.id));
      $display("cycle %0d: word %02h for requester %0d", cyc, e.data, e.id);
      m_dout = e.data;
      m_id   = e.id;
    end else begin
      check_val("dout_valid_idle", 32'(dout_valid), 32'd0);
      check_val("dout_hold", 32'(dout), 32'(m_dout));
      check_val("dout_id_hold", 32'(dout_id), 32'(m_id));
    end
    if (gnt != '0 && prev_gnt == '0) gnt_log.push_back(gnt);
    prev_gnt = gnt;
    act_rd = (fifo_rd_en === 1'b1);

    @(posedge clk);
    #1;
    w = 8'hEE;
    if (act_rd && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      fifo_rdata = w;
    end
    if (rs) begin
      m_busy = 1'b0;
      m_last = NREQ - 1;
      m_cnt  = 0;
      exp_q.delete();
      m_dout = '0;
      m_id   = 0;
    end else if (!m_busy) begin
      if (|r && !empty_now) begin
        m_owner = rr_pick(m_last, r);
        m_last  = m_owner;
        m_cnt   = 0;
        m_busy  = 1'b1;
      end
    end else begin
      if (exp_rd) begin
        e.data = w;
        e.id   = m_owner;
        e.due  = cyc + 2;
        exp_q.push_back(e);
        m_cnt++;
        pops_total++;
      end
      if (!r[m_owner] || m_cnt == BURST) m_busy = 1'b0;
    end
    cyc++;
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + DW'(i));
  endtask

  initial begin
    int  p0;
    bit  reached;

    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state, nothing requested.
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);

    // Single requester, six words A1..A6.
    fill(6, 8'hA1);
    gnt_log.delete();
    p0 = pops_total;
    for (int i = 0; i < 16; i++) cycle(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b0);
    check_val("single_pops", 32'(pops_total - p0), 32'd6);
    check_val("single_first_gnt", 32'(gnt_log.size() > 0 ? gnt_log[0] : 4'h0), 32'h1);

    // Round robin from reset, FIFO kept non-empty.
    cycle(4'b0000, 1'b0, 1'b1);
    gnt_log.delete();
    for (int i = 0; i < 28; i++) begin
      while (fifo_q.size() < 6) fifo_q.push_back(DW'($urandom_range(0, 255)));
      cycle(4'b1111, 1'b0, 1'b0);
    end
    check_val("rr_grants", 32'(gnt_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++)
      check_val("rr_order", 32'(gnt_log[k]), 32'(4'b0001 << (k % NREQ)));
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b0);

    // Early release: requester 2 drops after two pops, then 3 should win.
    cycle(4'b0000, 1'b0, 1'b1);
    fifo_q.delete();
    fill(12, 8'h40);
    gnt_log.delete();
    reached = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      cycle(4'b0100, 1'b0, 1'b0);
      reached = m_busy && (m_cnt == 2);
    end
    check_val("early_reached", 32'(reached), 32'd1);
    for (int i = 0; i < 10; i++) cycle(4'b1001, 1'b0, 1'b0);
    check_val("early_grants", 32'(gnt_log.size() >= 2), 32'd1);
    if (gnt_log.size() >= 2) begin
      check_val("early_first", 32'(gnt_log[0]), 32'h4);
      check_val("early_next", 32'(gnt_log[1]), 32'h8);
    end
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b0);

    // Empty stall after the first pop of a grant.
    cycle(4'b0000, 1'b0, 1'b1);
    fifo_q.delete();
    fill(4, 8'h60);
    p0 = pops_total;
    reached = 1'b0;
    for (int i = 0; i < 8 && !reached; i++) begin
      cycle(4'b0001, 1'b0, 1'b0);
      reached = m_busy && (m_cnt == 1);
    end
    check_val("stall_reached", 32'(reached), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0001, 1'b1, 1'b0);
      check_val("stall_gnt_held", 32'(gnt), 32'h1);
    end
    for (int i = 0; i < 6; i++) cycle(4'b0001, 1'b0, 1'b0);
    check_val("stall_pops", 32'(pops_total - p0), 32'd4);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b0);

    // Reset during the third pop of a burst.
    cycle(4'b0000, 1'b0, 1'b1);
    fifo_q.delete();
    fill(16, 8'h80);
    reached = 1'b0;
    for (int i = 0; i < 8 && !reached; i++) begin
      cycle(4'b1111, 1'b0, 1'b0);
      reached = m_busy && (m_cnt == 2);
    end
    check_val("rst_reached", 32'(reached), 32'd1);
    cycle(4'b1111, 1'b0, 1'b1);
    gnt_log.delete();
    for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b0, 1'b0);
    check_val("rst_next_gnt", 32'(gnt_log.size() > 0 ? gnt_log[0] : 4'h0), 32'h1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0, 1'b0);

    // All requesting against an empty FIFO.
    cycle(4'b0000, 1'b0, 1'b1);
    fifo_q.delete();
    for (int i = 0; i < 10; i++) cycle(4'b1111, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      if (fifo_q.size() < 10 && $urandom_range(0, 2) != 0)
        fifo_q.push_back(DW'($urandom_range(0, 255)));
      cycle(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
